// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP register-file write-back controller.
package fp_wb_pkg;

   localparam int unsigned NUM_REGS_DEF = 32;
   localparam int unsigned DATA_W_DEF   = 32;
   localparam int unsigned IDX_W_DEF    = 5;

   // Exception flag vector layout: {NV,DZ,OF,UF,NX}
   localparam int unsigned FLAG_W  = 5;
   localparam int unsigned FLAG_NX = 0;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_NV = 4;

   typedef enum logic [1:0] {
      FP_NONE  = 2'd0,
      FP_ARITH = 2'd1,
      FP_LOAD  = 2'd2,
      FP_STORE = 2'd3
   } fp_op_t;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_FPU  = 2'd1,
      WB_LOAD = 2'd2,
      WB_HOLD = 2'd3
   } wb_state_t;

endpackage

// File: rtl/f_scoreboard.sv
// Pending-write scoreboard for the FP register file with a three-index hazard query.
module f_scoreboard #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned IDX_W    = 5
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             i_set_en,
   input  logic [IDX_W-1:0] i_set_idx,
   input  logic             i_clr_en,
   input  logic [IDX_W-1:0] i_clr_idx,
   input  logic [IDX_W-1:0] i_q_rs1,
   input  logic [IDX_W-1:0] i_q_rs2,
   input  logic [IDX_W-1:0] i_q_rd,
   output logic [2:0]       o_hazard_c   // {rd, rs2, rs1}
);

   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_set_vec;
   logic [NUM_REGS-1:0] w_clr_vec;

   // One-hot decode of the set and clear indices
   always_comb begin
      w_set_vec = '0;
      w_clr_vec = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         w_set_vec[i] = i_set_en && (i_set_idx == IDX_W'(i));
         w_clr_vec[i] = i_clr_en && (i_clr_idx == IDX_W'(i));
      end
   end

   // Clear the written index, then mark the newly issued destination
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
      end
   end

   assign o_hazard_c = {r_pending[i_q_rd], r_pending[i_q_rs2], r_pending[i_q_rs1]};

endmodule

// File: rtl/f_writeback_ctrl.sv
// FP register-file write-port controller: issue gating, completion slots,
// write-port arbitration (FPU before load) and sticky exception flags.
module f_writeback_ctrl
   import fp_wb_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned IDX_W    = IDX_W_DEF
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  fp_op_t            issue_op,
   input  logic [IDX_W-1:0]  issue_rd,
   input  logic [IDX_W-1:0]  issue_rs1,
   input  logic [IDX_W-1:0]  issue_rs2,
   input  logic              fpu_ready,
   input  logic [DATA_W-1:0] fpu_result,
   input  logic [FLAG_W-1:0] fpu_flags,
   input  logic              dload_valid,
   input  logic [DATA_W-1:0] dload_data,
   output logic              f_wen,
   output logic [IDX_W-1:0]  f_rd,
   output logic [DATA_W-1:0] f_w_data,
   output logic [FLAG_W-1:0] fflags,
   input  logic              fflags_clr,
   output logic              busy
);

   // Completion slots
   logic              r_ar_valid;
   logic [IDX_W-1:0]  r_ar_rd;
   logic              r_ld_valid;
   logic [IDX_W-1:0]  r_ld_rd;

   // Load hold register for simultaneous completions
   logic              r_hold_valid;
   logic [IDX_W-1:0]  r_hold_rd;
   logic [DATA_W-1:0] r_hold_data;

   // Write-port state and registered outputs
   wb_state_t         r_state;
   wb_state_t         w_state_nxt;
   logic              r_f_wen;
   logic [IDX_W-1:0]  r_f_rd;
   logic [DATA_W-1:0] r_f_w_data;
   logic              w_wen_nxt;
   logic [IDX_W-1:0]  w_rd_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_drain;

   logic [FLAG_W-1:0] r_fflags;

   logic [2:0]        w_hazard;
   logic              w_ready;
   logic              w_accept;
   logic              w_acc_arith;
   logic              w_acc_load;
   logic              w_fpu_done;
   logic              w_ld_done;

   assign w_fpu_done  = fpu_ready   && r_ar_valid;
   assign w_ld_done   = dload_valid && r_ld_valid;
   assign w_accept    = issue_valid && w_ready;
   assign w_acc_arith = w_accept && (issue_op == FP_ARITH);
   assign w_acc_load  = w_accept && (issue_op == FP_LOAD);

   f_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_scoreboard (
      .CLK        (CLK),
      .nRST       (nRST),
      .i_set_en   (w_acc_arith || w_acc_load),
      .i_set_idx  (issue_rd),
      .i_clr_en   (r_f_wen),
      .i_clr_idx  (r_f_rd),
      .i_q_rs1    (issue_rs1),
      .i_q_rs2    (issue_rs2),
      .i_q_rd     (issue_rd),
      .o_hazard_c (w_hazard)
   );

   // Issue acceptance: blocked while a held load still owes a write
   always_comb begin
      w_ready = 1'b0;
      if (!r_hold_valid) begin
         case (issue_op)
            FP_ARITH: w_ready = !r_ar_valid && !(|w_hazard);
            FP_LOAD:  w_ready = !r_ld_valid && !w_hazard[2];
            FP_STORE: w_ready = !w_hazard[1];
            default:  w_ready = 1'b1;
         endcase
      end
   end

   // Completion slot occupancy
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_ar_valid <= 1'b0;
         r_ar_rd    <= '0;
         r_ld_valid <= 1'b0;
         r_ld_rd    <= '0;
      end else begin
         if (w_acc_arith) begin
            r_ar_valid <= 1'b1;
            r_ar_rd    <= issue_rd;
         end else if (w_fpu_done) begin
            r_ar_valid <= 1'b0;
         end
         if (w_acc_load) begin
            r_ld_valid <= 1'b1;
            r_ld_rd    <= issue_rd;
         end else if (w_ld_done) begin
            r_ld_valid <= 1'b0;
         end
      end
   end

   // Park the load when it collides with an FPU completion
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_hold_valid <= 1'b0;
         r_hold_rd    <= '0;
         r_hold_data  <= '0;
      end else if (w_fpu_done && w_ld_done) begin
         r_hold_valid <= 1'b1;
         r_hold_rd    <= r_ld_rd;
         r_hold_data  <= dload_data;
      end else if (w_drain) begin
         r_hold_valid <= 1'b0;
      end
   end

   // Write-port next state and next write values
   always_comb begin
      w_state_nxt = WB_IDLE;
      w_wen_nxt   = 1'b0;
      w_rd_nxt    = r_f_rd;
      w_data_nxt  = r_f_w_data;
      w_drain     = 1'b0;
      if ((r_state == WB_FPU) && r_hold_valid) begin
         w_state_nxt = WB_HOLD;
         w_wen_nxt   = 1'b1;
         w_rd_nxt    = r_hold_rd;
         w_data_nxt  = r_hold_data;
         w_drain     = 1'b1;
      end else if (w_fpu_done) begin
         w_state_nxt = WB_FPU;
         w_wen_nxt   = 1'b1;
         w_rd_nxt    = r_ar_rd;
         w_data_nxt  = fpu_result;
      end else if (w_ld_done) begin
         w_state_nxt = WB_LOAD;
         w_wen_nxt   = 1'b1;
         w_rd_nxt    = r_ld_rd;
         w_data_nxt  = dload_data;
      end
   end

   // Write-port state register and registered write outputs
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state    <= WB_IDLE;
         r_f_wen    <= 1'b0;
         r_f_rd     <= '0;
         r_f_w_data <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_f_wen    <= w_wen_nxt;
         r_f_rd     <= w_rd_nxt;
         r_f_w_data <= w_data_nxt;
      end
   end

   // Sticky flags; new flags win over a same-cycle clear
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_fflags <= '0;
      end else begin
         r_fflags <= (fflags_clr ? '0 : r_fflags) | (w_fpu_done ? fpu_flags : '0);
      end
   end

   assign issue_ready = w_ready;
   assign f_wen       = r_f_wen;
   assign f_rd        = r_f_rd;
   assign f_w_data    = r_f_w_data;
   assign fflags      = r_fflags;
   assign busy        = r_ar_valid || r_ld_valid || r_hold_valid || r_f_wen;

endmodule

// File: tb/tb_f_writeback_ctrl.sv
// Self-checking bench for f_writeback_ctrl: directed scenarios followed by
// random traffic checked against a queue-based reference model.
module tb_f_writeback_ctrl;
   import fp_wb_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        issue_valid;
   logic        issue_ready;
   fp_op_t      issue_op;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        fpu_ready;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_flags;
   logic        dload_valid;
   logic [31:0] dload_data;
   logic        f_wen;
   logic [4:0]  f_rd;
   logic [31:0] f_w_data;
   logic [4:0]  fflags;
   logic        fflags_clr;
   logic        busy;

   always #5 CLK = ~CLK;

   f_writeback_ctrl dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_rd    (issue_rd),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .fpu_ready   (fpu_ready),
      .fpu_result  (fpu_result),
      .fpu_flags   (fpu_flags),
      .dload_valid (dload_valid),
      .dload_data  (dload_data),
      .f_wen       (f_wen),
      .f_rd        (f_rd),
      .f_w_data    (f_w_data),
      .fflags      (fflags),
      .fflags_clr  (fflags_clr),
      .busy        (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: register writes are a FIFO drained one per cycle
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   bit          m_pend [32];
   bit          m_ar_v, m_ld_v;
   logic [4:0]  m_ar_rd, m_ld_rd;
   wr_t         m_q [$];
   bit          m_wen;
   logic [4:0]  m_wrd;
   logic [31:0] m_wdata;
   logic [4:0]  m_flags;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ar_v  = 1'b0; m_ld_v = 1'b0;
      m_ar_rd = '0;   m_ld_rd = '0;
      m_q.delete();
      m_wen   = 1'b0; m_wrd = '0; m_wdata = '0;
      m_flags = '0;
   endtask

   function automatic bit m_ready();
      if (m_q.size() != 0) return 1'b0;
      case (issue_op)
         FP_ARITH: return !m_ar_v && !m_pend[issue_rs1] && !m_pend[issue_rs2] && !m_pend[issue_rd];
         FP_LOAD:  return !m_ld_v && !m_pend[issue_rd];
         FP_STORE: return !m_pend[issue_rs2];
         default:  return 1'b1;
      endcase
   endfunction

   task automatic m_step(input bit acc);
      logic [4:0] newf;
      wr_t        w;
      newf = '0;
      if (m_wen) m_pend[m_wrd] = 1'b0;
      if (fpu_ready && m_ar_v) begin
         w.rd = m_ar_rd; w.data = fpu_result; m_q.push_back(w);
         newf = fpu_flags;
         m_ar_v = 1'b0;
      end
      if (dload_valid && m_ld_v) begin
         w.rd = m_ld_rd; w.data = dload_data; m_q.push_back(w);
         m_ld_v = 1'b0;
      end
      m_flags = (fflags_clr ? 5'd0 : m_flags) | newf;
      if (acc) begin
         if (issue_op == FP_ARITH) begin
            m_ar_v = 1'b1; m_ar_rd = issue_rd; m_pend[issue_rd] = 1'b1;
         end else if (issue_op == FP_LOAD) begin
            m_ld_v = 1'b1; m_ld_rd = issue_rd; m_pend[issue_rd] = 1'b1;
         end
      end
      if (m_q.size() > 0) begin
         w = m_q.pop_front();
         m_wen = 1'b1; m_wrd = w.rd; m_wdata = w.data;
      end else begin
         m_wen = 1'b0;
      end
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; issue_op = FP_NONE;
      issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
      fpu_ready = 1'b0; fpu_flags = '0;
      dload_valid = 1'b0; fflags_clr = 1'b0;
   endtask

   task automatic drive_issue(input fp_op_t op, input int rd, input int rs1, input int rs2);
      issue_valid = 1'b1; issue_op = op;
      issue_rd = 5'(rd); issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2);
   endtask

   // One clock cycle: entered and left just after a falling edge
   task automatic tick();
      bit exp_ready, acc, exp_busy;
      exp_ready = m_ready();
      chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
      acc = issue_valid && exp_ready;
      @(posedge CLK);
      m_step(acc);
      @(negedge CLK);
      chk("f_wen", 32'(f_wen), 32'(m_wen));
      if (m_wen) begin
         chk("f_rd", 32'(f_rd), 32'(m_wrd));
         chk("f_w_data", f_w_data, m_wdata);
      end
      chk("fflags", 32'(fflags), 32'(m_flags));
      exp_busy = m_ar_v || m_ld_v || (m_q.size() > 0) || m_wen;
      chk("busy", 32'(busy), 32'(exp_busy));
      idle_inputs();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_f_wen"},    32'(f_wen),       32'd0);
      chk({tag, "_f_rd"},     32'(f_rd),        32'd0);
      chk({tag, "_f_w_data"}, f_w_data,         32'd0);
      chk({tag, "_fflags"},   32'(fflags),      32'd0);
      chk({tag, "_busy"},     32'(busy),        32'd0);
      chk({tag, "_ready"},    32'(issue_ready), 32'd1);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #2;
      m_reset();
      chk_reset_state("reset");
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      fpu_result = '0; dload_data = '0;
      nRST = 1'b1;
      @(negedge CLK);
      do_reset();

      // ARITH rd=3, result 4 cycles later
      drive_issue(FP_ARITH, 3, 0, 0); tick();
      repeat (3) tick();
      fpu_ready = 1'b1; fpu_result = 32'h3F80_0000; fpu_flags = 5'(1 << FLAG_NX);
      tick();
      chk("t1_wen",  32'(f_wen),  32'd1);
      chk("t1_rd",   32'(f_rd),   32'd3);
      chk("t1_data", f_w_data,    32'h3F80_0000);
      chk("t1_flags",32'(fflags), 32'h01);
      tick();
      chk("t1_wen_off", 32'(f_wen), 32'd0);
      chk("t1_busy",    32'(busy),  32'd0);

      // RAW hazard on f5
      drive_issue(FP_ARITH, 5, 0, 0); tick();
      drive_issue(FP_ARITH, 6, 5, 0);
      chk("t2_stall0", 32'(issue_ready), 32'd0); tick();
      drive_issue(FP_ARITH, 6, 5, 0);
      fpu_ready = 1'b1; fpu_result = 32'hA5A5_0005;
      chk("t2_stall1", 32'(issue_ready), 32'd0); tick();
      drive_issue(FP_ARITH, 6, 5, 0);
      chk("t2_stall2", 32'(issue_ready), 32'd0); tick();
      drive_issue(FP_ARITH, 6, 5, 0);
      chk("t2_accept", 32'(issue_ready), 32'd1); tick();
      fpu_ready = 1'b1; fpu_result = 32'h0000_0006; tick();
      tick();

      // Simultaneous FPU and load completion
      drive_issue(FP_ARITH, 1, 0, 0); tick();
      drive_issue(FP_LOAD, 2, 0, 0); tick();
      tick();
      fpu_ready = 1'b1; fpu_result = 32'h1111_1111;
      dload_valid = 1'b1; dload_data = 32'h2222_2222;
      tick();
      chk("t3_w1_rd",   32'(f_rd), 32'd1);
      chk("t3_w1_data", f_w_data,  32'h1111_1111);
      drive_issue(FP_NONE, 0, 0, 0);
      chk("t3_ready_gap", 32'(issue_ready), 32'd0);
      tick();
      chk("t3_w2_wen",  32'(f_wen), 32'd1);
      chk("t3_w2_rd",   32'(f_rd),  32'd2);
      chk("t3_w2_data", f_w_data,   32'h2222_2222);
      tick();

      // Stray load pulse, then clear together with new flags
      dload_valid = 1'b1; dload_data = 32'hDEAD_BEEF; tick();
      chk("t4_no_wen", 32'(f_wen), 32'd0);
      drive_issue(FP_ARITH, 9, 1, 2);
      chk("t4_sb_clean", 32'(issue_ready), 32'd1); tick();
      fpu_ready = 1'b1; fpu_result = 32'h9; fpu_flags = 5'(1 << FLAG_NV); fflags_clr = 1'b1;
      tick();
      chk("t4_clr_keep", 32'(fflags), 32'h10);
      tick();

      // STORE waits on pending f7
      drive_issue(FP_ARITH, 7, 0, 0); tick();
      drive_issue(FP_STORE, 0, 0, 7);
      chk("t5_stall0", 32'(issue_ready), 32'd0); tick();
      drive_issue(FP_STORE, 0, 0, 7);
      fpu_ready = 1'b1; fpu_result = 32'h7777_0007; tick();
      drive_issue(FP_STORE, 0, 0, 7);
      chk("t5_stall1", 32'(issue_ready), 32'd0); tick();
      drive_issue(FP_STORE, 0, 0, 7);
      chk("t5_accept", 32'(issue_ready), 32'd1); tick();
      chk("t5_no_wen", 32'(f_wen), 32'd0);

      // Reset with both slots outstanding
      drive_issue(FP_ARITH, 10, 0, 0); tick();
      drive_issue(FP_LOAD, 11, 0, 0); tick();
      tick();
      do_reset();
      fpu_ready = 1'b1; fpu_result = 32'hBAD0_0001;
      dload_valid = 1'b1; dload_data = 32'hBAD0_0002;
      tick();
      chk_reset_state("t6_post");

      // Random traffic on a small register window to provoke hazards
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 699) == 0) begin
            do_reset();
         end
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_op    = fp_op_t'($urandom_range(0, 3));
         issue_rd    = 5'($urandom_range(0, 7));
         issue_rs1   = 5'($urandom_range(0, 7));
         issue_rs2   = 5'($urandom_range(0, 7));
         fpu_ready   = ($urandom_range(0, 4) == 0);
         fpu_result  = $urandom;
         fpu_flags   = 5'($urandom_range(0, 31));
         dload_valid = ($urandom_range(0, 4) == 0);
         dload_data  = $urandom;
         fflags_clr  = ($urandom_range(0, 19) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
